// File: rtl/rdn_pkg.sv
// Shared constants, RDN network weight counts and the line-fetch state encoding
// for the weight memory responder.
package rdn_pkg;

  localparam int WORDS_PER_LINE = 32;

  // Layer weight counts: A = 15x401, B = 15x16, C = 36x16
  localparam int RDN_A_NEURONS = 15;
  localparam int RDN_A_FANIN   = 401;
  localparam int RDN_B_NEURONS = 15;
  localparam int RDN_B_FANIN   = 16;
  localparam int RDN_C_NEURONS = 36;
  localparam int RDN_C_FANIN   = 16;

  localparam int RDN_A_WEIGHTS = RDN_A_NEURONS * RDN_A_FANIN;
  localparam int RDN_B_WEIGHTS = RDN_B_NEURONS * RDN_B_FANIN;
  localparam int RDN_C_WEIGHTS = RDN_C_NEURONS * RDN_C_FANIN;
  localparam int RDN_TOTAL_WEIGHTS = RDN_A_WEIGHTS + RDN_B_WEIGHTS + RDN_C_WEIGHTS;

  function automatic int lines_for(input int weights, input int words_per_line);
    return (weights + words_per_line - 1) / words_per_line;
  endfunction

  localparam int RDN_TOTAL_LINES = lines_for(RDN_TOTAL_WEIGHTS, WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } rdn_state_e;

endpackage

// File: rtl/rdn_weight_mem_rsp_if.sv
// Loader-side and backing-memory-side signals of the weight memory responder.
// The slave modport is the responder's view, master is the environment's view.
interface rdn_weight_mem_rsp_if #(
  parameter int WORDS_PER_LINE = rdn_pkg::WORDS_PER_LINE,
  parameter int ADDR_W         = 16
) ();

  logic                    go;
  logic [ADDR_W-1:0]       base_addr;
  logic                    req_mem;
  logic                    mem_ready;
  logic signed [15:0]      mem_data [WORDS_PER_LINE];
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_valid;
  logic signed [15:0]      rd_data;
  logic                    busy;
  logic [8:0]              line_cnt;

  modport slave (
    input  go, base_addr, req_mem, rd_valid, rd_data,
    output mem_ready, mem_data, rd_en, rd_addr, busy, line_cnt
  );

  modport master (
    output go, base_addr, req_mem, rd_valid, rd_data,
    input  mem_ready, mem_data, rd_en, rd_addr, busy, line_cnt
  );

endinterface

// File: rtl/rdn_line_buf.sv
// Double-buffered weight line: words land in a shadow copy one at a time and the
// whole line moves to the output registers on a single commit edge.
module rdn_line_buf #(
  parameter int WORDS = 32,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic signed [15:0] wr_data,
  input  logic               commit,
  output logic signed [15:0] line_data [WORDS],
  output logic               line_ready
);

  logic line_ready_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic signed [15:0] shadow_reg;
      logic signed [15:0] out_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
          out_reg    <= '0;
        end else begin
          if (wr_en && (wr_idx == IDX_W'(gi))) begin
            shadow_reg <= wr_data;
          end
          if (commit) begin
            out_reg <= shadow_reg;
          end
        end
      end

      assign line_data[gi] = out_reg;
    end
  endgenerate

  // Ready rises on the same edge the output line changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_ready_reg <= 1'b0;
    end else begin
      line_ready_reg <= commit;
    end
  end

  assign line_ready = line_ready_reg;

endmodule

// File: rtl/rdn_weight_mem_rsp.sv
// Serves weight lines to the RDN loader: fetches WORDS_PER_LINE words one at a time
// from single-word backing memory, then presents the whole line at once.
module rdn_weight_mem_rsp #(
  parameter int WORDS_PER_LINE = rdn_pkg::WORDS_PER_LINE,
  parameter int ADDR_W         = 16,
  parameter int RD_TAG_EN      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rdn_weight_mem_rsp_if.slave  bus
);

  import rdn_pkg::*;

  localparam int                IDX_W        = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [8:0]        LINE_CNT_MAX = 9'd511;

  rdn_state_e          state_reg, state_next;
  logic                pending_reg, pending_next;
  logic [ADDR_W-1:0]   addr_ptr_reg;
  logic [IDX_W-1:0]    word_idx_reg;
  logic [8:0]          line_cnt_reg;

  logic                start_session;
  logic                word_accept;
  logic                commit;
  logic signed [15:0]  line_data [WORDS_PER_LINE];
  logic                line_ready;

  // Tagged reads are reserved for a future memory port; no behaviour yet
  generate
    if (RD_TAG_EN != 0) begin : g_rd_tag_reserved
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    start_session = 1'b0;
    word_accept   = 1'b0;
    commit        = 1'b0;

    case (state_reg)
      IDLE: begin
        // go wins over a simultaneous req_mem
        if (bus.go) begin
          start_session = 1'b1;
          state_next    = ISSUE;
        end else if (bus.req_mem) begin
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        state_next = WAIT;
        if (bus.req_mem) begin
          pending_next = 1'b1;
        end
      end

      WAIT: begin
        if (bus.req_mem) begin
          pending_next = 1'b1;
        end
        if (bus.rd_valid) begin
          word_accept = 1'b1;
          state_next  = (word_idx_reg == LAST_IDX) ? DONE : ISSUE;
        end
      end

      DONE: begin
        // A request landing in this final cycle is honoured like a pending one
        commit       = 1'b1;
        pending_next = 1'b0;
        state_next   = (pending_reg || bus.req_mem) ? ISSUE : IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pending_reg  <= 1'b0;
      addr_ptr_reg <= '0;
      word_idx_reg <= '0;
      line_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (start_session) begin
        addr_ptr_reg <= bus.base_addr;
        word_idx_reg <= '0;
        line_cnt_reg <= '0;
      end else if (word_accept) begin
        addr_ptr_reg <= addr_ptr_reg + ADDR_W'(1);
        word_idx_reg <= word_idx_reg + IDX_W'(1);
      end else if (commit) begin
        word_idx_reg <= '0;
        if (line_cnt_reg != LINE_CNT_MAX) begin
          line_cnt_reg <= line_cnt_reg + 9'd1;
        end
      end
    end
  end

  rdn_line_buf #(
    .WORDS (WORDS_PER_LINE),
    .IDX_W (IDX_W)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (word_accept),
    .wr_idx     (word_idx_reg),
    .wr_data    (bus.rd_data),
    .commit     (commit),
    .line_data  (line_data),
    .line_ready (line_ready)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_out
      assign bus.mem_data[gi] = line_data[gi];
    end
  endgenerate

  assign bus.rd_en     = (state_reg == ISSUE);
  assign bus.rd_addr   = addr_ptr_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.line_cnt  = line_cnt_reg;
  assign bus.mem_ready = line_ready;

endmodule

// File: tb/tb_rdn_weight_mem_rsp.sv
// Directed bench for rdn_weight_mem_rsp: a latency-programmable memory responder
// plus hand-derived expectations for line contents, order, timing and reset.
module tb_rdn_weight_mem_rsp;

  localparam int WPL = 32;
  localparam int AW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rdn_weight_mem_rsp_if #(.WORDS_PER_LINE(WPL), .ADDR_W(AW)) bus ();

  rdn_weight_mem_rsp #(
    .WORDS_PER_LINE (WPL),
    .ADDR_W         (AW),
    .RD_TAG_EN      (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int lat_fixed = 1;
  bit lat_rand = 1'b0;
  int overlap_cnt = 0;
  int ready_cnt = 0;
  int cyc_now = 0;
  logic [15:0] addr_log [$];

  function automatic logic signed [15:0] model_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_now <= cyc_now + 1;
  always @(negedge clk) if (bus.mem_ready === 1'b1) ready_cnt <= ready_cnt + 1;

  // Backing memory: answers each read exactly L cycles after rd_en
  initial begin : responder
    int cnt;
    bit outst;
    logic [15:0] a;
    cnt = 0;
    outst = 1'b0;
    a = '0;
    bus.rd_valid = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      bus.rd_valid = 1'b0;
      if (outst) begin
        cnt--;
        if (cnt == 0) begin
          bus.rd_valid = 1'b1;
          bus.rd_data = model_word(a);
          outst = 1'b0;
        end
      end
      if (bus.rd_en === 1'b1) begin
        if (outst) overlap_cnt++;
        a = bus.rd_addr;
        addr_log.push_back(a);
        cnt = lat_rand ? int'($urandom_range(7, 1)) : lat_fixed;
        outst = 1'b1;
      end
    end
  end

  task automatic pulse_go(input logic [15:0] base);
    @(negedge clk);
    bus.base_addr = base;
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    bus.req_mem = 1'b1;
    @(posedge clk);
    #1;
    bus.req_mem = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.mem_ready === 1'b1) seen = 1'b1;
    end
    chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
    $display("line %s: line_cnt=%0d cycles=%0d word0=%h", tag, bus.line_cnt, cycles, bus.mem_data[0]);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (addr_log.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, "_reads_reached"}, 32'(addr_log.size() >= n), 32'd1);
  endtask

  task automatic check_line(input string tag, input logic [15:0] base);
    int errs;
    errs = 0;
    for (int i = 0; i < WPL; i++) begin
      if (bus.mem_data[i] !== model_word(base + 16'(i))) errs++;
    end
    chk({tag, "_w0"}, 32'(bus.mem_data[0]), 32'(model_word(base)));
    chk({tag, "_w31"}, 32'(bus.mem_data[WPL-1]), 32'(model_word(base + 16'(WPL - 1))));
    chk({tag, "_words_wrong"}, errs, 0);
  endtask

  task automatic check_addrs(input string tag, input int s, input logic [15:0] base, input int n);
    int errs;
    errs = 0;
    if (addr_log.size() < s + n) begin
      errs = n;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (addr_log[s + i] !== base + 16'(i)) errs++;
      end
    end
    chk({tag, "_addr_order_wrong"}, errs, 0);
  endtask

  initial begin : main
    int s;
    int cyc;
    int rc;
    int t0;
    logic signed [15:0] old_w0;

    bus.go = 1'b0;
    bus.req_mem = 1'b0;
    bus.base_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_line_cnt", 32'(bus.line_cnt), 32'd0);
    chk("rst_data0", 32'(bus.mem_data[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First line of a session, latency 1
    lat_fixed = 1;
    s = addr_log.size();
    pulse_go(16'h0100);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_ready("t1", 300, cyc);
    chk("t1_latency", cyc, 65);
    check_line("t1", 16'h0100);
    check_addrs("t1", s, 16'h0100, 32);
    chk("t1_read_count", addr_log.size() - s, 32);
    chk("t1_line_cnt", 32'(bus.line_cnt), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_ready_one_cycle", 32'(bus.mem_ready), 32'd0);
    chk("t1_idle", 32'(bus.busy), 32'd0);

    // Three follow-on lines; output must hold while the next one fetches
    for (int k = 1; k <= 3; k++) begin
      old_w0 = model_word(16'h0100 + 16'(32 * (k - 1)));
      s = addr_log.size();
      pulse_req();
      repeat (20) @(posedge clk);
      #1;
      chk("t2_data_stable", 32'(bus.mem_data[0]), 32'(old_w0));
      wait_ready("t2", 300, cyc);
      check_line("t2", 16'h0100 + 16'(32 * k));
      check_addrs("t2", s, 16'h0100 + 16'(32 * k), 32);
    end
    chk("t2_line_cnt", 32'(bus.line_cnt), 32'd4);

    // Requests at words 5 and 10: one queued, second dropped
    s = addr_log.size();
    pulse_req();
    wait_log("t3a", s + 6, 200);
    pulse_req();
    wait_log("t3b", s + 11, 200);
    pulse_req();
    rc = ready_cnt;
    wait_ready("t3_first", 300, cyc);
    check_line("t3_first", 16'h0180);
    wait_ready("t3_second", 300, cyc);
    chk("t3_back_to_back_gap", cyc, 65);
    check_line("t3_second", 16'h01A0);
    check_addrs("t3", s, 16'h0180, 64);
    repeat (150) @(posedge clk);
    #1;
    chk("t3_ready_count", ready_cnt - rc, 2);
    chk("t3_idle", 32'(bus.busy), 32'd0);
    chk("t3_line_cnt", 32'(bus.line_cnt), 32'd6);

    // Random memory latency 1..7
    lat_rand = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s = addr_log.size();
      pulse_req();
      wait_ready("t4", 800, cyc);
      check_line("t4", 16'h01C0 + 16'(32 * k));
      check_addrs("t4", s, 16'h01C0 + 16'(32 * k), 32);
    end
    lat_rand = 1'b0;
    chk("t4_overlapping_reads", overlap_cnt, 0);
    chk("t4_line_cnt", 32'(bus.line_cnt), 32'd8);

    // Reset at word 17 with latency 3; the late rd_valid lands after reset
    lat_fixed = 3;
    repeat (10) @(posedge clk);
    s = addr_log.size();
    pulse_go(16'h0200);
    wait_log("t5", s + 18, 400);
    rc = ready_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("t5_rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("t5_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_line_cnt", 32'(bus.line_cnt), 32'd0);
    chk("t5_rst_data0", 32'(bus.mem_data[0]), 32'd0);
    chk("t5_rst_data31", 32'(bus.mem_data[WPL-1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_ready_after_rst", ready_cnt - rc, 0);
    chk("t5_idle_after_rst", 32'(bus.busy), 32'd0);
    chk("t5_line_cnt_after_rst", 32'(bus.line_cnt), 32'd0);
    lat_fixed = 1;
    s = addr_log.size();
    pulse_go(16'h0200);
    wait_ready("t5_refetch", 300, cyc);
    check_addrs("t5_refetch", s, 16'h0200, 32);
    check_line("t5_refetch", 16'h0200);
    chk("t5_line_cnt", 32'(bus.line_cnt), 32'd1);

    // Address wrap
    s = addr_log.size();
    pulse_go(16'hFFF0);
    wait_ready("t6", 300, cyc);
    chk("t6_addr_word15", (addr_log.size() > s + 15) ? 32'(addr_log[s + 15]) : 32'hDEAD, 32'h0000FFFF);
    chk("t6_addr_word16", (addr_log.size() > s + 16) ? 32'(addr_log[s + 16]) : 32'hDEAD, 32'h00000000);
    check_line("t6", 16'hFFF0);

    // Full 214-line session
    t0 = cyc_now;
    pulse_go(16'h0000);
    wait_ready("t7_line", 300, cyc);
    for (int k = 1; k < 214; k++) begin
      pulse_req();
      wait_ready("t7_line", 300, cyc);
    end
    chk("t7_line_cnt", 32'(bus.line_cnt), 32'd214);
    chk("t7_within_20000", 32'((cyc_now - t0) < 20000), 32'd1);
    check_line("t7_last", 16'h1AA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
